// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and flag-vector layout
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_NEG      = 3;
  localparam int FLAG_W        = 4;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/add_group.sv
// rtl/add_group.sv - GROUP-bit combinational lookahead adder with group generate/propagate
module add_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);

  logic c;
  logic gacc;
  logic pacc;

  always_comb begin
    sum  = '0;
    c    = cin;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      gacc   = (a[i] & b[i]) | ((a[i] ^ b[i]) & gacc);
      pacc   = pacc & (a[i] ^ b[i]);
    end
  end

  assign cout = c;
  assign g    = gacc;
  assign p    = pacc;

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module add_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int L = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
    $error("add_pipe: WIDTH must be a positive multiple of GROUP");
  end

  // Index 0 is the capture register; stage k resolves group k-1 into s_q[k].
  logic             v_q   [0:L];
  logic [WIDTH-1:0] a_q   [0:L-1];
  logic [WIDTH-1:0] b_q   [0:L-1];
  logic             c_q   [0:L-1];
  logic [WIDTH-1:0] s_q   [1:L];
  logic [WIDTH-1:0] snext [1:L];
  logic             cnext [1:L];
  flags_t           flags_q;

  logic             adv;
  logic             sub;
  logic [WIDTH-1:0] b_in;

  assign sub      = (in_op == ALU_OP_SUB);
  assign b_in     = sub ? ~in_b : in_b;
  assign adv      = !v_q[L] || out_ready;
  assign in_ready = adv && !reset;

  for (genvar k = 1; k <= L; k++) begin : g_stage
    logic [GROUP-1:0] gsum;
    logic             gcout;
    logic             gg;
    logic             gp;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] snew;

    add_group #(.GROUP(GROUP)) u_group (
      .a    (a_q[k-1][(k-1)*GROUP +: GROUP]),
      .b    (b_q[k-1][(k-1)*GROUP +: GROUP]),
      .cin  (c_q[k-1]),
      .sum  (gsum),
      .cout (gcout),
      .g    (gg),
      .p    (gp)
    );

    if (k == 1) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = s_q[k-1];
    end

    always_comb begin
      snew = prev;
      snew[(k-1)*GROUP +: GROUP] = gsum;
    end

    // The ripple carry and the G/P lookahead form must always agree.
    always_comb begin
      assert (gcout == (gg | (gp & c_q[k-1])));
    end

    assign snext[k] = snew;
    assign cnext[k] = gcout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= L; k++) v_q[k] <= 1'b0;
      for (int k = 0; k < L; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      for (int k = 1; k <= L; k++) s_q[k] <= '0;
      flags_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      a_q[0] <= in_a;
      b_q[0] <= b_in;
      c_q[0] <= sub;
      for (int k = 1; k <= L; k++) begin
        v_q[k] <= v_q[k-1];
        s_q[k] <= snext[k];
      end
      for (int k = 1; k < L; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= cnext[k];
      end
      flags_q[FLAG_CARRY]    <= cnext[L];
      flags_q[FLAG_OVERFLOW] <= (a_q[L-1][WIDTH-1] == b_q[L-1][WIDTH-1]) &&
                                (snext[L][WIDTH-1] != a_q[L-1][WIDTH-1]);
      flags_q[FLAG_ZERO]     <= ~|snext[L];
      flags_q[FLAG_NEG]      <= snext[L][WIDTH-1];
    end
  end

  assign out_valid    = v_q[L];
  assign out_result   = s_q[L];
  assign out_carry    = flags_q[FLAG_CARRY];
  assign out_overflow = flags_q[FLAG_OVERFLOW];
  assign out_zero     = flags_q[FLAG_ZERO];
  assign out_neg      = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - directed and randomized checks of add_pipe at 32/8 and 16/4
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        iv, iop, ordy, ir, ov, oc, oo, oz, on;
  logic [31:0] ia, ib, ores;

  logic        iv16, iop16, ordy16, ir16, ov16, oc16, oo16, oz16, on16;
  logic [15:0] ia16, ib16, ores16;

  int errors = 0;
  int checks = 0;

  add_pipe #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clock(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_op(iop),
    .in_a(ia), .in_b(ib), .out_valid(ov), .out_ready(ordy), .out_result(ores),
    .out_carry(oc), .out_overflow(oo), .out_zero(oz), .out_neg(on)
  );

  add_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clock(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_op(iop16),
    .in_a(ia16), .in_b(ib16), .out_valid(ov16), .out_ready(ordy16), .out_result(ores16),
    .out_carry(oc16), .out_overflow(oo16), .out_zero(oz16), .out_neg(on16)
  );

  logic        top [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ta  [8] = '{32'h1, 32'hA, 32'h10, 32'h0, 32'h12345678, 32'h100, 32'h7FFFFFFF, 32'hF0000000};
  logic [31:0] tb  [8] = '{32'h2, 32'h3, 32'h20, 32'h1, 32'h11111111, 32'h80, 32'h0, 32'h10000000};
  logic [31:0] te  [8] = '{32'h3, 32'h7, 32'h30, 32'hFFFFFFFF, 32'h23456789, 32'h80, 32'h7FFFFFFF, 32'h0};

  // Present one beat at posedge+1; returns with outputs sampled on the first out_valid.
  task automatic issue32(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit acc);
    iv = 1'b1; iop = op; ia = a; ib = b;
    #1;
    acc = ir;
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 0;
    while (!ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue16(input logic op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output bit acc);
    iv16 = 1'b1; iop16 = op; ia16 = a; ib16 = b;
    #1;
    acc = ir16;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    iv = 1'b0; iop = 1'b0; ia = '0; ib = '0; ordy = 1'b1;
    iv16 = 1'b0; iop16 = 1'b0; ia16 = '0; ib16 = '0; ordy16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov); end
    checks++; if (ores !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", ores); end
    checks++; if ({oc, oo, oz, on} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {oc, oo, oz, on}); end
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", ir); end
    checks++; if (ov16 !== 1'b0 || ir16 !== 1'b0) begin errors++; $display("FAIL reset_dut16: got valid=%b ready=%b want 0 0", ov16, ir16); end
    reset = 1'b0;
    #1;
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ir); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    int lat; bit acc;
    issue32(1'b0, 32'hFFFFFFFF, 32'h00000001, lat, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL add_wrap_accept: got %b want 1", acc); end
    checks++; if (lat != 4) begin errors++; $display("FAIL add_wrap_latency: got %0d want 4", lat); end
    checks++; if (ores !== 32'h0) begin errors++; $display("FAIL add_wrap_result: got %h want 00000000", ores); end
    checks++; if ({oc, oo, oz, on} !== 4'b1010) begin errors++; $display("FAIL add_wrap_flags: got cozn=%b want 1010", {oc, oo, oz, on}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_overflow();
    int lat; bit acc;
    issue32(1'b1, 32'h80000000, 32'h00000001, lat, acc);
    checks++; if (lat != 4 || ores !== 32'h7FFFFFFF) begin errors++; $display("FAIL sub_ovf_result: got %h lat %0d want 7fffffff lat 4", ores, lat); end
    checks++; if ({oc, oo, oz, on} !== 4'b1100) begin errors++; $display("FAIL sub_ovf_flags: got cozn=%b want 1100", {oc, oo, oz, on}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_borrow();
    int lat; bit acc;
    issue32(1'b1, 32'h00000005, 32'h00000007, lat, acc);
    checks++; if (lat != 4 || ores !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_borrow_result: got %h lat %0d want fffffffe lat 4", ores, lat); end
    checks++; if ({oc, oo, oz, on} !== 4'b0001) begin errors++; $display("FAIL sub_borrow_flags: got cozn=%b want 0001", {oc, oo, oz, on}); end
    @(posedge clk); #1;
    issue32(1'b1, 32'h00001234, 32'h00001234, lat, acc);
    checks++; if (ores !== 32'h0 || {oc, oo, oz, on} !== 4'b1010) begin errors++; $display("FAIL sub_equal: got %h cozn=%b want 00000000 1010", ores, {oc, oo, oz, on}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, stall = 0, cyc = 0;
    bit seen = 1'b0;
    logic [31:0] held = '0;
    ordy = 1'b1;
    while (got < 8 && cyc < 80) begin
      if (ov && !seen) begin seen = 1'b1; stall = 3; held = ores; end
      ordy = (stall == 0);
      if (stall > 0) begin
        checks++;
        if (ov !== 1'b1 || ores !== held) begin errors++; $display("FAIL stall_hold: got valid=%b res=%h want 1 %h", ov, ores, held); end
      end
      if (sent < 8) begin iv = 1'b1; iop = top[sent]; ia = ta[sent]; ib = tb[sent]; end
      else iv = 1'b0;
      #1;
      if (stall > 0) begin
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", ir); end
      end
      if (ov && ordy) begin
        checks++;
        if (ores !== te[got]) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, ores, te[got]); end
        got++;
      end
      if (iv && ir) sent++;
      if (stall > 0) stall--;
      @(posedge clk); #1;
      cyc++;
    end
    iv = 1'b0; ordy = 1'b1;
    checks++; if (got != 8 || !seen) begin errors++; $display("FAIL b2b_count: got %0d results want 8", got); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_extra: got valid=%b after 8 results want 0", ov); end
  endtask

  task automatic test_reset_flush();
    int lat, stray = 0; bit acc;
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; iop = 1'b0; ia = 32'h100 + i; ib = 32'h0;
      #1;
      checks++; if (ir !== 1'b1) begin errors++; $display("FAIL flush_accept[%0d]: got %b want 1", i, ir); end
      @(posedge clk); #1;
    end
    iv = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL flush_ready_in_reset: got %b want 0", ir); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (ov !== 1'b0 || ores !== 32'h0) begin errors++; $display("FAIL flush_after_reset: got valid=%b res=%h want 0 00000000", ov, ores); end
    for (int i = 0; i < 8; i++) begin
      if (ov) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush_stray: got %0d stray results want 0", stray); end
    issue32(1'b0, 32'hAAAA0000, 32'h00005555, lat, acc);
    checks++; if (lat != 4 || ores !== 32'hAAAA5555) begin errors++; $display("FAIL flush_next: got %h lat %0d want aaaa5555 lat 4", ores, lat); end
    checks++; if ({oc, oo, oz, on} !== 4'b0001) begin errors++; $display("FAIL flush_next_flags: got cozn=%b want 0001", {oc, oo, oz, on}); end
    @(posedge clk); #1;
  endtask

  task automatic test_w16_overflow();
    int lat; bit acc;
    issue16(1'b0, 16'h7FFF, 16'h0001, lat, acc);
    checks++; if (acc !== 1'b1 || lat != 4) begin errors++; $display("FAIL w16_latency: got acc=%b lat=%0d want 1 4", acc, lat); end
    checks++; if (ores16 !== 16'h8000) begin errors++; $display("FAIL w16_result: got %h want 8000", ores16); end
    checks++; if ({oc16, oo16, oz16, on16} !== 4'b0101) begin errors++; $display("FAIL w16_flags: got cozn=%b want 0101", {oc16, oo16, oz16, on16}); end
    @(posedge clk); #1;
  endtask

  task automatic test_random16();
    logic [19:0] q[$];
    logic [19:0] exp_v;
    logic [16:0] t;
    logic [15:0] r;
    logic c, o;
    int sent = 0, cyc = 0;
    while (!(sent == 150 && q.size() == 0) && cyc < 4000) begin
      ordy16 = ($urandom_range(0, 3) != 0);
      if (sent < 150) begin
        iv16  = ($urandom_range(0, 4) != 0);
        iop16 = 1'($urandom);
        ia16  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        ib16  = ($urandom_range(0, 7) == 0) ? ia16 : 16'($urandom);
      end else iv16 = 1'b0;
      #1;
      if (ov16 && ordy16) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand16_unexpected: got %h with no beat outstanding", ores16);
        end else begin
          exp_v = q.pop_front();
          if ({ores16, oc16, oo16, oz16, on16} !== exp_v)
            begin errors++; $display("FAIL rand16_result: got %h cozn=%b want %h cozn=%b", ores16, {oc16, oo16, oz16, on16}, exp_v[19:4], exp_v[3:0]); end
        end
      end
      if (iv16 && ir16) begin
        if (iop16) begin
          r = ia16 - ib16;
          c = (ia16 >= ib16);
          o = (ia16[15] != ib16[15]) && (r[15] != ia16[15]);
        end else begin
          t = {1'b0, ia16} + {1'b0, ib16};
          r = t[15:0];
          c = t[16];
          o = (ia16[15] == ib16[15]) && (r[15] != ia16[15]);
        end
        q.push_back({r, c, o, (r == 16'h0), r[15]});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv16 = 1'b0; ordy16 = 1'b1;
    checks++; if (sent != 150 || q.size() != 0) begin errors++; $display("FAIL rand16_drain: got sent=%0d pending=%0d want 150 0", sent, q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_overflow();
    test_sub_borrow();
    test_back_to_back();
    test_reset_flush();
    test_w16_overflow();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
